// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding and frame constants for the memory-dump UART transmitter.
package uart_pkg;
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, START, DATA, STOP, DONE} state_t;
  localparam int CLKS_PER_BIT_DEF = 5;
  localparam int DATA_BITS = 8;
  localparam int BYTES_PER_WORD = 4;
endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: single-byte 8N1 serializer with back-to-back frame support.
module uart_tx_byte
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       Tx_Serial,
  output logic       ready
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  state_t state;
  logic [CW-1:0] cnt;
  logic [2:0] bit_idx;
  logic [7:0] sh;
  logic last;
  assign last = cnt == CW'(CLKS_PER_BIT - 1);
  // ready also covers the final stop cycle so the next start bit follows with no gap
  assign ready = state == IDLE || (state == STOP && last);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      bit_idx <= '0;
      sh <= '0;
      Tx_Serial <= 1'b1;
    end else if (start && ready) begin
      state <= START;
      cnt <= '0;
      sh <= data;
      Tx_Serial <= 1'b0;
    end else if (state != IDLE) begin
      cnt <= last ? '0 : cnt + 1'b1;
      if (last)
        case (state)
          START: begin
            state <= DATA;
            bit_idx <= '0;
            Tx_Serial <= sh[0];
          end
          DATA:
            if (bit_idx == 3'(DATA_BITS - 1)) begin
              state <= STOP;
              Tx_Serial <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              sh <= sh >> 1;
              Tx_Serial <= sh[1];
            end
          default: begin
            state <= IDLE;
            Tx_Serial <= 1'b1;
          end
        endcase
    end
endmodule

// File: rtl/uart_mem_tx.sv
// uart_mem_tx: on a mem2uart rising edge, reads NUM_WORDS words from memory and sends them LSB byte first as 8N1 frames.
module uart_mem_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int NUM_WORDS = 25,
  parameter int BASE_ADDR = 0,
  parameter int ADDR_W = 8
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic              mem2uart,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  output logic              Tx_Serial,
  output logic              busy,
  output logic              done
);
  localparam int WW = NUM_WORDS > 1 ? $clog2(NUM_WORDS) : 1;
  state_t state;
  logic m_q, trig, start, ready, last_byte;
  logic [WW-1:0] word_idx;
  logic [1:0] byte_idx;
  logic [23:0] sw;
  logic [7:0] byte_data;
  assign last_byte = byte_idx == 2'(BYTES_PER_WORD - 1);
  // the first byte is taken straight from the read port so its start bit lands right after LOAD
  assign byte_data = state == LOAD ? mem_rdata[7:0] : sw[7:0];
  assign start = state == LOAD || (state == DATA && ready && !last_byte);
  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clk(sysclk),
    .rst_n(reset),
    .start(start),
    .data(byte_data),
    .Tx_Serial(Tx_Serial),
    .ready(ready)
  );
  always_ff @(posedge sysclk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      m_q <= 1'b0;
      trig <= 1'b0;
      word_idx <= '0;
      byte_idx <= '0;
      sw <= '0;
      mem_rd <= 1'b0;
      mem_addr <= ADDR_W'(BASE_ADDR);
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      m_q <= mem2uart;
      trig <= mem2uart && !m_q && state == IDLE;
      case (state)
        IDLE:
          if (trig) begin
            state <= FETCH;
            mem_rd <= 1'b1;
            mem_addr <= ADDR_W'(BASE_ADDR);
            word_idx <= '0;
            busy <= 1'b1;
          end
        FETCH: begin
          state <= LOAD;
          mem_rd <= 1'b0;
        end
        LOAD: begin
          state <= DATA;
          sw <= mem_rdata[31:8];
          byte_idx <= '0;
        end
        DATA:
          if (ready) begin
            if (!last_byte) begin
              byte_idx <= byte_idx + 1'b1;
              sw <= sw >> 8;
            end else if (word_idx == WW'(NUM_WORDS - 1)) begin
              state <= DONE;
              busy <= 1'b0;
              done <= 1'b1;
            end else begin
              state <= FETCH;
              mem_rd <= 1'b1;
              mem_addr <= mem_addr + 1'b1;
              word_idx <= word_idx + 1'b1;
            end
          end
        DONE: begin
          state <= IDLE;
          done <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_mem_tx.sv
// tb_uart_mem_tx: scoreboard bench; a mid-bit sampling receiver decodes Tx_Serial against the memory image.
module tb_uart_mem_tx;
  localparam int CPB = 5;
  logic sysclk = 1'b0;
  logic reset = 1'b0;
  logic m2u_1 = 1'b0, m2u_f = 1'b0;
  logic rd_1, rd_f, tx_1, tx_f, busy_1, busy_f, done_1, done_f;
  logic [7:0] addr_1, addr_f;
  logic [31:0] rdata_1, rdata_f;
  logic [31:0] mem [256];
  logic sel = 1'b0;
  logic line, done_s, busy_s, rd_s;
  logic [7:0] addr_s;
  int cyc = 0, t0 = 0, n_tests = 0, n_fail = 0, dump_id = 0, rst_gen = 0;
  logic [7:0] exp_q[$];

  always #5 sysclk = ~sysclk;
  always @(posedge sysclk) cyc <= cyc + 1;
  always @(posedge sysclk) if (rd_1) rdata_1 <= mem[addr_1];
  always @(posedge sysclk) if (rd_f) rdata_f <= mem[addr_f];

  assign line = sel ? tx_f : tx_1;
  assign done_s = sel ? done_f : done_1;
  assign busy_s = sel ? busy_f : busy_1;
  assign rd_s = sel ? rd_f : rd_1;
  assign addr_s = sel ? addr_f : addr_1;

  uart_mem_tx #(.CLKS_PER_BIT(CPB), .NUM_WORDS(1)) u_one (
    .sysclk(sysclk), .reset(reset), .mem2uart(m2u_1), .mem_rd(rd_1), .mem_addr(addr_1),
    .mem_rdata(rdata_1), .Tx_Serial(tx_1), .busy(busy_1), .done(done_1)
  );
  uart_mem_tx #(.CLKS_PER_BIT(CPB)) u_full (
    .sysclk(sysclk), .reset(reset), .mem2uart(m2u_f), .mem_rd(rd_f), .mem_addr(addr_f),
    .mem_rdata(rdata_f), .Tx_Serial(tx_f), .busy(busy_f), .done(done_f)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc - t0);
    end
  endtask

  // receiver: detect start at negedge, sample each bit mid-period
  always begin
    int st, g, prev, frame_n, last_id;
    logic [7:0] b;
    logic stp;
    @(negedge sysclk);
    if (line === 1'b0) begin
      st = cyc;
      g = rst_gen;
      repeat (CPB / 2) @(negedge sysclk);
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge sysclk);
        b[i] = line;
      end
      repeat (CPB) @(negedge sysclk);
      stp = line;
      if (g == rst_gen) begin
        if (dump_id != last_id) begin
          frame_n = 0;
          last_id = dump_id;
        end
        check("frame_start", frame_n == 0 ? st - t0 : st - prev,
              frame_n == 0 ? 3 : (frame_n % 4 == 0 ? 52 : 50));
        if (exp_q.size() == 0) check("rx_extra_frame", 1, 0);
        else check("rx_byte", b, exp_q.pop_front());
        check("stop_bit", stp, 1);
        prev = st;
        frame_n++;
      end
    end
  end

  task automatic trigger(input logic f);
    sel = f;
    @(negedge sysclk);
    if (f) m2u_f = 1'b0; else m2u_1 = 1'b0;
    @(negedge sysclk);
    for (int w = 0; w < (f ? 25 : 1); w++)
      for (int b = 0; b < 4; b++) exp_q.push_back(mem[w][8*b +: 8]);
    dump_id++;
    if (f) m2u_f = 1'b1; else m2u_1 = 1'b1;
    t0 = cyc + 1;
    @(negedge sysclk);
    check("rd_cycle0", rd_s, 0);
    @(negedge sysclk);
    check("rd_cycle1", rd_s, 1);
    check("addr_cycle1", addr_s, 0);
    check("busy_cycle1", busy_s, 1);
    @(negedge sysclk);
    check("rd_cycle2", rd_s, 0);
    check("tx_cycle2", line, 1);
    @(negedge sysclk);
    check("tx_cycle3", line, 0);
  endtask

  task automatic wait_done(input int exp);
    int k = 0;
    while (done_s !== 1'b1 && k < 7000) begin
      @(negedge sysclk);
      k++;
    end
    check("done_cycle", k < 7000 ? 64'(cyc - t0) : '1, exp);
    check("busy_at_done", busy_s, 0);
    check("tx_at_done", line, 1);
    @(negedge sysclk);
    check("done_one_cycle", done_s, 0);
    check("rx_all_frames", exp_q.size(), 0);
  endtask

  initial begin
    int bad;
    mem[0] = 32'h12345678;
    for (int i = 1; i < 256; i++) mem[i] = i;
    repeat (3) @(negedge sysclk);
    check("reset_addr", addr_f, 0);
    check("reset_tx", tx_f, 1);
    reset = 1'b1;
    bad = 0;
    repeat (100) begin
      @(negedge sysclk);
      bad += int'(tx_1 !== 1'b1 || tx_f !== 1'b1 || busy_1 || busy_f || done_1 || done_f || rd_1 || rd_f);
    end
    check("idle_after_reset", bad, 0);
    trigger(1'b0);
    wait_done(203);
    mem[0] = 32'h0;
    trigger(1'b1);
    while (cyc < t0 + 110) @(negedge sysclk);
    check("tx_before_reset", tx_f, 0);
    #2 reset = 1'b0;
    rst_gen++;
    m2u_f = 1'b0;
    #1 check("tx_async_reset", tx_f, 1);
    check("busy_async_reset", busy_f, 0);
    exp_q.delete();
    bad = 0;
    repeat (10) begin
      @(negedge sysclk);
      bad += int'(done_f === 1'b1);
    end
    reset = 1'b1;
    repeat (60) begin
      @(negedge sysclk);
      bad += int'(done_f === 1'b1 || busy_f === 1'b1);
    end
    check("no_done_after_abort", bad, 0);
    trigger(1'b1);
    repeat (1000) @(negedge sysclk);
    m2u_f = 1'b0;
    repeat (10) @(negedge sysclk);
    m2u_f = 1'b1;
    wait_done(5051);
    bad = 0;
    repeat (300) begin
      @(negedge sysclk);
      bad += int'(busy_f || rd_f);
    end
    check("held_high_no_retrigger", bad, 0);
    trigger(1'b1);
    wait_done(5051);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1);
  end
endmodule

// File: doc/uart_mem_tx.md
Name: uart_mem_tx

Overview:
Dumps a block of data memory out of the board's serial line on request. It is the transmit counterpart of the CPU's UART receive path. On a rising edge of mem2uart it reads NUM_WORDS 32-bit words, starting at BASE_ADDR, through a synchronous memory read port. Each word is sent least-significant byte first as UART 8N1 frames on Tx_Serial, at the same bit timing the receive path uses.

Parameters:
CLKS_PER_BIT, 5, sysclk cycles per serial bit (must be >= 2)
NUM_WORDS, 25, words sent per dump (must be >= 1)
BASE_ADDR, 0, word address of the first word
ADDR_W, 8, memory word-address width

Ports:
sysclk  input  1  system clock; all logic on the rising edge
reset  input  1  asynchronous, active-low reset
mem2uart  input  1  dump request, level; only a 0->1 transition triggers
mem_rd  output  1  memory read strobe
mem_addr  output  ADDR_W  word address being read
mem_rdata  input  32  read data, valid the cycle after mem_rd
Tx_Serial  output  1  serial line, idle high
busy  output  1  high while a dump is in progress
done  output  1  one-cycle pulse when a dump completes

Behaviour:
- Reset (reset=0, async): Tx_Serial=1, busy=0, done=0, mem_rd=0, mem_addr=BASE_ADDR, all counters 0, state IDLE. mem2uart edge history is cleared to 0.
- Trigger: mem2uart is registered once. "Cycle 0" is the rising edge where mem2uart=1 and the previous sample was 0. The trigger is ignored unless state=IDLE.
- A held-high mem2uart never retriggers. A new dump needs mem2uart to fall and rise again after done.
- States: IDLE -> FETCH -> LOAD -> START -> DATA -> STOP -> (next byte: START | next word: FETCH | last: DONE) -> IDLE.
- FETCH, cycle 1: mem_rd=1 and mem_addr=BASE_ADDR+word_idx. busy=1 from cycle 1.
- LOAD, cycle 2: mem_rdata is captured into a 32-bit shift word, and byte_idx=0.
- START: Tx_Serial=0 for CLKS_PER_BIT cycles. The first start bit begins in cycle 3.
- DATA: bits [0..7] of the current byte, LSB first, each held for CLKS_PER_BIT cycles.
- STOP: Tx_Serial=1 for CLKS_PER_BIT cycles.
- Bytes within a word are sent in the order [7:0], [15:8], [23:16], [31:24]. There is no gap between bytes: a stop bit is followed directly by the next start bit.
- Between words, FETCH and LOAD take 2 cycles with Tx_Serial=1. One word therefore occupies exactly 2 + 40*CLKS_PER_BIT cycles (202 at default).
- After the last stop bit of word NUM_WORDS-1, DONE lasts one cycle: done=1, busy=0, Tx_Serial=1. The state then returns to IDLE.
- For N words at default timing, the last stop bit ends at cycle 202*N and done is high in cycle 202*N+1 (5051 for N=25).
- Counters: baud counter counts 0..CLKS_PER_BIT-1; bit_idx counts 0..7; byte_idx counts 0..3; word_idx counts 0..NUM_WORDS-1. The address is computed modulo 2^ADDR_W, so it wraps silently.
- mem_rd is high only in FETCH cycles. mem_addr holds its last value otherwise.
- Async reset mid-frame: the line returns high immediately and the dump is abandoned. No done pulse is produced.
- Tx_Serial is driven from a register (glitch-free).

Decomposition:
- Package uart_pkg holds:
  - the state enum (IDLE, FETCH, LOAD, START, DATA, STOP, DONE);
  - the default CLKS_PER_BIT;
  - frame constants: DATA_BITS=8, BYTES_PER_WORD=4.
- Sub-module uart_tx_byte: a single-byte 8N1 serializer.
  - Inputs: start, data[7:0].
  - Outputs: Tx_Serial, ready.
  - It owns the baud and bit counters and the START/DATA/STOP states.
- uart_mem_tx keeps the trigger detect, fetch sequencing and word/byte indexing.

Test Plan:
- Reset values: hold reset=0, then release it with mem2uart=0 for 100 cycles -> Tx_Serial=1, busy=0, done=0, mem_rd=0 throughout.
- Single word: NUM_WORDS=1, mem[0]=0x12345678, raise mem2uart -> mem_rd=1 with mem_addr=0 in cycle 1.
  - Tx_Serial falls in cycle 3.
  - Sampling mid-bit gives bytes 0x78, 0x56, 0x34, 0x12; the first byte's data bits are 0,0,0,1,1,1,1,0.
  - done is high only in cycle 203.
- Full dump: mem[i]=i for i=0..24 -> 100 frames decode as 00,00,00,00, 01,00,00,00, ..., 18,00,00,00.
  - There are exactly 2 idle-high cycles between words.
  - done is high in cycle 5051.
- Retrigger rules: hold mem2uart high after done -> no second dump. Pulse mem2uart in the middle of a dump -> ignored, frame timing unchanged. Drop and raise mem2uart after done -> a new dump starts with mem_addr=BASE_ADDR.
- Reset mid-frame: assert reset during the DATA bits of byte 2 -> Tx_Serial=1 asynchronously, busy=0, no done pulse. A following trigger restarts from word 0.
- Loopback: feed Tx_Serial back into the CPU's UART receive path with CLKS_PER_BIT=5 -> the received bytes match the memory image byte-for-byte.
